set_job_host: RTL and testbench



---
 rtl/set_pkg.sv | 25 ++
 rtl/set_job_fifo.sv | 46 ++++
 rtl/set_job_host.sv | 166 ++++++++++++++++
 tb/tb_set_job_host.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/set_pkg.sv
// Shared types for the SET engine host: job record, host FSM states, mode codes.
// Job tags are carried at SET_TAG_MAX_W bits; the host narrows them to TAG_W.
package set_pkg;

  localparam int SET_TAG_MAX_W = 8;

  localparam logic [1:0] SET_MODE_A     = 2'b00;
  localparam logic [1:0] SET_MODE_A_AND = 2'b01;
  localparam logic [1:0] SET_MODE_A_XOR = 2'b10;

  typedef struct packed {
    logic [23:0]              central;
    logic [11:0]              radius;
    logic [1:0]               mode;
    logic [SET_TAG_MAX_W-1:0] tag;
  } set_job_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } set_host_state_e;

endpackage

// File: rtl/set_job_fifo.sv
// Synchronous job FIFO; pointers carry one extra wrap bit to tell full from empty.
module set_job_fifo
  import set_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     i_push,
  input  set_job_t i_push_data,
  input  logic     i_pop,
  output set_job_t o_head,
  output logic     o_full,
  output logic     o_empty
);

  localparam int AW = $clog2(DEPTH);

  set_job_t       r_mem [DEPTH];
  logic [AW:0]    r_wr_ptr;
  logic [AW:0]    r_rd_ptr;
  logic           w_do_push;
  logic           w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/set_job_host.sv
// Host controller for one SET engine: buffers jobs, runs them one at a time, returns tagged results.
// Optional watchdog on the engine run is enabled with the SET_HOST_TIMEOUT_EN macro.
module set_job_host
  import set_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TAG_W          = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [23:0]      job_central,
  input  logic [11:0]      job_radius,
  input  logic [1:0]       job_mode,
  input  logic [TAG_W-1:0] job_tag,
  output logic             en,
  output logic [23:0]      central,
  output logic [11:0]      radius,
  output logic [1:0]       mode,
  input  logic             busy,
  input  logic             valid,
  input  logic [7:0]       candidate,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_candidate,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_timeout,
  output logic             idle,
  output logic [1:0]       dbg_state
);

  // Both streams use valid/ready: a transfer happens on a clock edge where both are high;
  // the source holds its payload steady while valid is high and ready is low.

  set_host_state_e  r_state;
  set_host_state_e  w_next_state;
  set_job_t         w_push_job;
  set_job_t         w_head;
  set_job_t         r_job;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_capture;
  logic             r_res_valid;
  logic [7:0]       r_res_candidate;
  logic [TAG_W-1:0] r_res_tag;

  always_comb begin
    w_push_job         = '0;
    w_push_job.central = job_central;
    w_push_job.radius  = job_radius;
    w_push_job.mode    = job_mode;
    w_push_job.tag     = SET_TAG_MAX_W'(job_tag);
  end

  set_job_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (job_valid),
    .i_push_data (w_push_job),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

`ifdef SET_HOST_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] r_wd_cnt;
  logic            w_wd_fire;
  logic            r_res_timeout;

  always_ff @(posedge clk) begin
    if (rst || r_state == ST_ISSUE) r_wd_cnt <= '0;
    else if (r_state == ST_WAIT)    r_wd_cnt <= r_wd_cnt + 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_capture    = 1'b0;
`ifdef SET_HOST_TIMEOUT_EN
    w_wd_fire    = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && !r_res_valid && !busy) begin
          w_pop        = 1'b1;
          w_next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: w_next_state = ST_WAIT;
      ST_WAIT: begin
        if (valid) begin
          w_capture    = 1'b1;
          w_next_state = ST_GAP;
        end
`ifdef SET_HOST_TIMEOUT_EN
        else if (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
          w_wd_fire    = 1'b1;
          w_next_state = ST_GAP;
        end
`endif
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Operands latch on pop and stay put until the next pop, covering ISSUE through GAP.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_job           <= '0;
      r_res_valid     <= 1'b0;
      r_res_candidate <= '0;
      r_res_tag       <= '0;
`ifdef SET_HOST_TIMEOUT_EN
      r_res_timeout   <= 1'b0;
`endif
    end else begin
      if (w_pop) r_job <= w_head;
      if (r_res_valid && res_ready) r_res_valid <= 1'b0;
      if (w_capture) begin
        r_res_valid     <= 1'b1;
        r_res_candidate <= candidate;
        r_res_tag       <= TAG_W'(r_job.tag);
`ifdef SET_HOST_TIMEOUT_EN
        r_res_timeout   <= 1'b0;
`endif
      end
`ifdef SET_HOST_TIMEOUT_EN
      if (w_wd_fire) begin
        r_res_valid     <= 1'b1;
        r_res_candidate <= '0;
        r_res_tag       <= TAG_W'(r_job.tag);
        r_res_timeout   <= 1'b1;
      end
`endif
    end
  end

`ifdef SET_HOST_TIMEOUT_EN
  assign res_timeout = r_res_timeout;
`else
  assign res_timeout = 1'b0;
`endif

  assign job_ready     = !w_full;
  assign en            = (r_state == ST_ISSUE);
  assign central       = r_job.central;
  assign radius        = r_job.radius;
  assign mode          = r_job.mode;
  assign res_valid     = r_res_valid;
  assign res_candidate = r_res_candidate;
  assign res_tag       = r_res_tag;
  assign idle          = w_empty && (r_state == ST_IDLE) && !r_res_valid;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_set_job_host.sv
// Bench for set_job_host: a behavioural SET engine stub, a lattice-count reference model and a result scoreboard.
module tb_set_job_host;
  import set_pkg::*;

  localparam int TAG_W = 4;
  localparam int EW    = TAG_W + 9;

  typedef struct {
    logic [23:0]      central;
    logic [11:0]      radius;
    logic [1:0]       mode;
    logic [TAG_W-1:0] tag;
  } tb_job_t;

  logic             clk;
  logic             rst;
  logic             job_valid;
  logic             job_ready;
  logic [23:0]      job_central;
  logic [11:0]      job_radius;
  logic [1:0]       job_mode;
  logic [TAG_W-1:0] job_tag;
  logic             en;
  logic [23:0]      central;
  logic [11:0]      radius;
  logic [1:0]       mode;
  logic             busy;
  logic             valid;
  logic [7:0]       candidate;
  logic             res_valid;
  logic             res_ready;
  logic [7:0]       res_candidate;
  logic [TAG_W-1:0] res_tag;
  logic             res_timeout;
  logic             idle;
  logic [1:0]       dbg_state;

  set_job_host #(.FIFO_DEPTH(4), .TAG_W(TAG_W), .TIMEOUT_CYCLES(1023)) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_central(job_central), .job_radius(job_radius), .job_mode(job_mode), .job_tag(job_tag),
    .en(en), .central(central), .radius(radius), .mode(mode),
    .busy(busy), .valid(valid), .candidate(candidate),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_candidate(res_candidate), .res_tag(res_tag), .res_timeout(res_timeout),
    .idle(idle), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int en_count = 0;
  int cyc      = 0;
  int last_valid_cyc = -100;
  logic prev_en = 1'b0;

  tb_job_t       job_q[$];
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] got_q[$];

  bit stub_never = 0;
  bit stub_rand  = 0;
  int stub_lat   = 3;
  bit rr_random  = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1, "global timeout");
  end

  // ---------------- reference model ----------------
  // Engine scans an 8x8 grid; a point is inside a circle when its squared distance <= r^2.
  function automatic int ref_count(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
    int ax, ay, bx, by, ra, rb, n;
    bit in_a, in_b;
    ax = int'(c[23:20]); ay = int'(c[19:16]);
    bx = int'(c[15:12]); by = int'(c[11:8]);
    ra = int'(r[11:8]);  rb = int'(r[7:4]);
    n = 0;
    for (int x = 0; x < 8; x++) begin
      for (int y = 0; y < 8; y++) begin
        in_a = ((x - ax) * (x - ax) + (y - ay) * (y - ay)) <= ra * ra;
        in_b = ((x - bx) * (x - bx) + (y - by) * (y - by)) <= rb * rb;
        if (m == 2'b00)      n += int'(in_a);
        else if (m == 2'b01) n += int'(in_a && in_b);
        else                 n += int'(in_a != in_b);
      end
    end
    return n;
  endfunction

  function automatic tb_job_t rand_job();
    tb_job_t j;
    j.central = 24'($urandom);
    j.radius  = 12'($urandom);
    j.mode    = 2'($urandom_range(0, 3));
    j.tag     = TAG_W'($urandom_range(0, 15));
    return j;
  endfunction

  // ---------------- engine stub ----------------
  initial begin
    tb_job_t j;
    int lat;
    busy = 1'b0; valid = 1'b0; candidate = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst && en === 1'b1) begin
        en_count++;
        n_checks++;
        if (job_q.size() == 0) begin
          n_fail++;
          $display("FAIL en_without_job: got en=1 expected no issue");
        end else begin
          j = job_q.pop_front();
          if ({central, radius, mode} !== {j.central, j.radius, j.mode}) begin
            n_fail++;
            $display("FAIL operands: got %h/%h/%h expected %h/%h/%h",
                     central, radius, mode, j.central, j.radius, j.mode);
          end
          if (!stub_never)
            exp_q.push_back({1'b0, j.tag, 8'(ref_count(j.central, j.radius, j.mode))});
`ifdef SET_HOST_TIMEOUT_EN
          else
            exp_q.push_back({1'b1, j.tag, 8'd0});
`endif
        end
        busy = 1'b1;
        if (stub_never) begin
          while (stub_never && !rst) begin @(posedge clk); #1; end
        end else begin
          lat = stub_rand ? int'($urandom_range(1, 6)) : stub_lat;
          while (lat > 0 && !rst) begin @(posedge clk); #1; lat--; end
          if (!rst) begin
            valid = 1'b1;
            candidate = 8'(ref_count(central, radius, mode));
            @(posedge clk); #1;
            valid = 1'b0;
          end
        end
        busy = 1'b0;
      end
    end
  end

  // ---------------- random result backpressure ----------------
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rr_random) res_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    cyc++;
    if (!rst) begin
      if (valid) last_valid_cyc = cyc;
      if (en) begin
        n_checks++;
        if (prev_en) begin
          n_fail++;
          $display("FAIL en_width: got en high 2 cycles expected 1");
        end else if (res_valid) begin
          n_fail++;
          $display("FAIL en_slot_full: got en with res_valid=1 expected no issue");
        end else if (cyc - last_valid_cyc < 2) begin
          n_fail++;
          $display("FAIL en_spacing: got %0d cycles after valid expected >=2", cyc - last_valid_cyc);
        end
      end
      if (res_valid && res_ready) begin
        n_checks++;
        got_q.push_back({res_timeout, res_tag, res_candidate});
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_result: got tag=%0h cand=%0d expected none", res_tag, res_candidate);
        end else begin
          e = exp_q.pop_front();
          if ({res_timeout, res_tag, res_candidate} !== e) begin
            n_fail++;
            $display("FAIL result: got to=%0b tag=%0h cand=%0d expected to=%0b tag=%0h cand=%0d",
                     res_timeout, res_tag, res_candidate, e[EW-1], e[EW-2:8], e[7:0]);
          end
        end
      end
    end
    prev_en = en;
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_job(input tb_job_t j);
    int guard;
    bit ok;
    guard = 0; ok = 0;
    job_valid = 1'b1; job_central = j.central; job_radius = j.radius;
    job_mode = j.mode; job_tag = j.tag;
    while (guard < 400) begin
      @(negedge clk);
      if (job_ready) begin
        job_q.push_back(j);
        @(posedge clk); #1;
        ok = 1;
        break;
      end
      @(posedge clk); #1;
      guard++;
    end
    job_valid = 1'b0;
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL push_timeout: got job_ready=0 expected accept within 400 cycles");
    end
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (!(exp_q.size() == 0 && job_q.size() == 0 && idle === 1'b1) && k < budget) begin
      step(1); k++;
    end
    n_checks++;
    if (k >= budget) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size() + job_q.size());
    end
  endtask

  task automatic abort_reset();
    rst = 1'b1;
    step(1);
    n_checks++;
    if ({en, res_valid, idle} !== 3'b001) begin
      n_fail++;
      $display("FAIL reset_abort: got en=%0b res_valid=%0b idle=%0b expected 0/0/1", en, res_valid, idle);
    end
    stub_never = 0;
    rst = 1'b0;
    job_q.delete();
    exp_q.delete();
    step(2);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    step(3);
    n_checks++;
    if ({en, res_valid, res_timeout, res_candidate, res_tag} !== '0) begin
      n_fail++;
      $display("FAIL reset_result: got %b expected 0", {en, res_valid, res_timeout, res_candidate, res_tag});
    end
    n_checks++;
    if ({central, radius, mode} !== '0) begin
      n_fail++;
      $display("FAIL reset_operands: got %h expected 0", {central, radius, mode});
    end
    n_checks++;
    if ({job_ready, idle} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_flags: got job_ready=%0b idle=%0b expected 1/1", job_ready, idle);
    end
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_single_job();
    tb_job_t j;
    int k;
    j.central = {4'd4, 4'd4, 4'd4, 4'd4, 4'd0, 4'd0};
    j.radius = {4'd3, 4'd3, 4'd0}; j.mode = 2'b00; j.tag = 4'd5;
    res_ready = 1'b0; stub_lat = 4;
    push_job(j);
    n_checks++;
    if (en !== 1'b0) begin n_fail++; $display("FAIL en_early: got %0b expected 0", en); end
    step(1);
    n_checks++;
    if (en !== 1'b1) begin n_fail++; $display("FAIL en_latency: got %0b expected 1", en); end
    step(1);
    n_checks++;
    if (en !== 1'b0) begin n_fail++; $display("FAIL en_pulse: got %0b expected 0", en); end
    k = 0;
    while (valid !== 1'b1 && k < 50) begin step(1); k++; end
    n_checks++;
    if (res_valid !== 1'b0) begin n_fail++; $display("FAIL res_before_valid: got %0b expected 0", res_valid); end
    step(1);
    n_checks++;
    if (res_valid !== 1'b1) begin n_fail++; $display("FAIL res_latency: got %0b expected 1", res_valid); end
    n_checks++;
    if (res_candidate !== 8'd29 || res_tag !== 4'd5 || res_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL single_result: got cand=%0d tag=%0h to=%0b expected 29/5/0", res_candidate, res_tag, res_timeout);
    end
    step(3);
    n_checks++;
    if (res_valid !== 1'b1) begin n_fail++; $display("FAIL res_hold: got %0b expected 1", res_valid); end
    res_ready = 1'b1;
    wait_drain(100);
  endtask

  task automatic test_back_to_back();
    tb_job_t j;
    int base;
    logic [7:0] want [3];
    want[0] = 8'd29; want[1] = 8'd29; want[2] = 8'd0;
    base = got_q.size();
    res_ready = 1'b1; stub_lat = 3;
    for (int i = 0; i < 3; i++) begin
      j.central = {4'd4, 4'd4, 4'd4, 4'd4, 4'd0, 4'd0};
      j.radius = {4'd3, 4'd3, 4'd0};
      j.mode = (i == 0) ? 2'b00 : (i == 1) ? 2'b01 : 2'b10;
      j.tag = TAG_W'(i + 1);
      push_job(j);
    end
    wait_drain(200);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (got_q.size() <= base + i) begin
        n_fail++;
        $display("FAIL b2b_missing_%0d: got none expected cand=%0d", i, want[i]);
      end else if (got_q[base + i][7:0] !== want[i] || got_q[base + i][EW-2:8] !== TAG_W'(i + 1)) begin
        n_fail++;
        $display("FAIL b2b_%0d: got cand=%0d tag=%0h expected cand=%0d tag=%0h",
                 i, got_q[base + i][7:0], got_q[base + i][EW-2:8], want[i], i + 1);
      end
    end
  endtask

  task automatic test_fifo_full();
    int en_base, got_base;
    res_ready = 1'b0; stub_lat = 2;
    en_base = en_count; got_base = got_q.size();
    for (int i = 0; i < 5; i++) push_job(rand_job());
    n_checks++;
    if (job_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %0b expected 0", job_ready); end
    step(30);
    n_checks++;
    if (en_count - en_base != 1) begin
      n_fail++; $display("FAIL full_issue_count: got %0d expected 1", en_count - en_base);
    end
    n_checks++;
    if (res_valid !== 1'b1 || got_q.size() != got_base) begin
      n_fail++; $display("FAIL full_slot: got res_valid=%0b drained=%0d expected 1/0", res_valid, got_q.size() - got_base);
    end
    res_ready = 1'b1;
    wait_drain(300);
    n_checks++;
    if (en_count - en_base != 5) begin
      n_fail++; $display("FAIL full_total: got %0d expected 5", en_count - en_base);
    end
  endtask

  task automatic test_timeout();
    tb_job_t j;
    int k;
    j = rand_job();
    res_ready = 1'b1; stub_never = 1;
    push_job(j);
`ifdef SET_HOST_TIMEOUT_EN
    k = 0;
    while (res_valid !== 1'b1 && k < 1200) begin step(1); k++; end
    n_checks++;
    if (res_valid !== 1'b1 || res_timeout !== 1'b1 || res_candidate !== 8'd0 || res_tag !== j.tag) begin
      n_fail++;
      $display("FAIL timeout_result: got v=%0b to=%0b cand=%0d tag=%0h expected 1/1/0/%0h",
               res_valid, res_timeout, res_candidate, res_tag, j.tag);
    end
    n_checks++;
    if (k < 1000) begin n_fail++; $display("FAIL timeout_early: got %0d cycles expected >=1000", k); end
    step(2);
    stub_never = 0;
    wait_drain(100);
`else
    k = 0;
    step(1100);
    n_checks++;
    if (dbg_state !== 2'(ST_WAIT) || res_valid !== 1'b0 || res_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_unbounded: got state=%0d res_valid=%0b expected WAIT/0", dbg_state, res_valid);
    end
    abort_reset();
`endif
  endtask

  task automatic test_reset_mid_job();
    int base;
    stub_never = 1; res_ready = 1'b1;
    push_job(rand_job());
    step(6);
    abort_reset();
    base = got_q.size();
    stub_lat = 3;
    push_job(rand_job());
    wait_drain(100);
    n_checks++;
    if (got_q.size() != base + 1) begin
      n_fail++; $display("FAIL after_reset_job: got %0d results expected 1", got_q.size() - base);
    end
  endtask

  task automatic test_stray_valid();
    int en_base, got_base;
    wait_drain(100);
    en_base = en_count; got_base = got_q.size();
    valid = 1'b1; candidate = 8'h33;
    step(1);
    valid = 1'b0;
    step(10);
    n_checks++;
    if (res_valid !== 1'b0 || idle !== 1'b1 || en_count != en_base || got_q.size() != got_base) begin
      n_fail++;
      $display("FAIL stray_valid: got res_valid=%0b idle=%0b expected 0/1", res_valid, idle);
    end
  endtask

  task automatic test_random();
    stub_rand = 1; rr_random = 1;
    for (int i = 0; i < 12; i++) begin
      push_job(rand_job());
      step($urandom_range(0, 3));
    end
    wait_drain(2000);
    rr_random = 0; stub_rand = 0;
    res_ready = 1'b1;
    step(2);
  endtask

  initial begin
    rst = 1'b1; job_valid = 1'b0; job_central = '0; job_radius = '0;
    job_mode = '0; job_tag = '0; res_ready = 1'b0;
    test_reset();
    test_single_job();
    test_back_to_back();
    test_fifo_full();
    test_stray_valid();
    test_timeout();
    test_reset_mid_job();
    test_random();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL leftover_expected: got %0d expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
